// File: rtl/drrip_duel_ctrl_if.sv
// Request/bank bundle for the DRRIP set-dueling controller.
// master drives the access and bank status; slave is the controller.
interface drrip_duel_ctrl_if #(
    parameter int INDEX_WIDTH = 5,
    parameter int M           = 2,
    parameter int PSEL_WIDTH  = 10
);
    logic                   req_valid;
    logic                   req_ready;
    logic [INDEX_WIDTH-1:0] req_index;
    logic                   req_hit;
    logic                   distant_found;
    logic                   fill_ack;
    logic                   promote_en;
    logic                   age_en;
    logic                   fill_en;
    logic [M-1:0]           insert_rrpv;
    logic                   policy_brrip;
    logic [PSEL_WIDTH-1:0]  psel;
    logic                   done;
    logic                   age_err;

    modport master (
        output req_valid,
        output req_index,
        output req_hit,
        output distant_found,
        output fill_ack,
        input  req_ready,
        input  promote_en,
        input  age_en,
        input  fill_en,
        input  insert_rrpv,
        input  policy_brrip,
        input  psel,
        input  done,
        input  age_err
    );

    modport slave (
        input  req_valid,
        input  req_index,
        input  req_hit,
        input  distant_found,
        input  fill_ack,
        output req_ready,
        output promote_en,
        output age_en,
        output fill_en,
        output insert_rrpv,
        output policy_brrip,
        output psel,
        output done,
        output age_err
    );
endinterface

// File: rtl/drrip_duel_ctrl.sv
// DRRIP set-dueling controller: leader classification, PSEL,
// and promote/search/age/fill sequencing of the RRPV bank.
module drrip_duel_ctrl #(
    parameter int INDEX_WIDTH     = 5,
    parameter int M               = 2,
    parameter int PSEL_WIDTH      = 10,
    parameter int DUEL_BITS       = 3,
    parameter int BRRIP_CNT_WIDTH = 5
) (
    input logic              clk,
    input logic              rst_n,
    drrip_duel_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PROMOTE,
        SEARCH,
        AGE,
        WAIT_FILL,
        FILL
    } state_t;

    localparam logic [M-1:0] DISTANT = '1;
    localparam logic [M-1:0] LONG    = {{(M-1){1'b1}}, 1'b0};
    localparam logic [M-1:0] AGE_MAX = '1;

    localparam logic [PSEL_WIDTH-1:0] PSEL_INIT =
        {1'b0, {(PSEL_WIDTH-1){1'b1}}};
    localparam logic [PSEL_WIDTH-1:0] PSEL_MAX = '1;

    state_t state_q;
    state_t state_d;

    logic [PSEL_WIDTH-1:0]      psel_q;
    logic                       policy_q;
    logic [M-1:0]               age_cnt_q;
    logic                       age_err_q;
    logic [BRRIP_CNT_WIDTH-1:0] brrip_cnt_q;

    logic [DUEL_BITS-1:0] duel_idx;
    logic                 is_srrip;
    logic                 is_brrip;
    logic                 accept;
    logic                 age_bound;

    assign duel_idx  = bus.req_index[DUEL_BITS-1:0];
    assign is_srrip  = (duel_idx == '0);
    assign is_brrip  = (duel_idx == '1);
    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign age_bound = (age_cnt_q == AGE_MAX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = bus.req_hit ? PROMOTE : SEARCH;
                end
            end
            PROMOTE: state_d = IDLE;
            SEARCH: begin
                if (bus.distant_found || age_bound) begin
                    state_d = WAIT_FILL;
                end else begin
                    state_d = AGE;
                end
            end
            AGE: state_d = SEARCH;
            WAIT_FILL: begin
                if (bus.fill_ack) begin
                    state_d = FILL;
                end
            end
            FILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Followers read psel before this cycle's update; only leaders move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel_q   <= PSEL_INIT;
            policy_q <= 1'b0;
        end else if (accept) begin
            if (is_srrip) begin
                policy_q <= 1'b0;
            end else if (is_brrip) begin
                policy_q <= 1'b1;
            end else begin
                policy_q <= psel_q[PSEL_WIDTH-1];
            end
            if (!bus.req_hit) begin
                if (is_srrip && (psel_q != PSEL_MAX)) begin
                    psel_q <= psel_q + 1'b1;
                end else if (is_brrip && (psel_q != '0)) begin
                    psel_q <= psel_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_cnt_q <= '0;
        end else if (accept) begin
            age_cnt_q <= '0;
        end else if (state_q == AGE) begin
            age_cnt_q <= age_cnt_q + 1'b1;
        end
    end

    // No DISTANT way after a full aging sweep: the bank falls back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_err_q <= 1'b0;
        end else if ((state_q == SEARCH) && !bus.distant_found
                     && age_bound) begin
            age_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brrip_cnt_q <= '0;
        end else if ((state_q == FILL) && policy_q) begin
            brrip_cnt_q <= brrip_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.req_ready    = (state_q == IDLE);
        bus.promote_en   = (state_q == PROMOTE);
        bus.age_en       = (state_q == AGE);
        bus.fill_en      = (state_q == FILL);
        bus.done         = (state_q == PROMOTE) || (state_q == FILL);
        bus.policy_brrip = policy_q;
        bus.psel         = psel_q;
        bus.age_err      = age_err_q;
        bus.insert_rrpv  = '0;
        if (state_q == FILL) begin
            if (policy_q && (brrip_cnt_q != '0)) begin
                bus.insert_rrpv = DISTANT;
            end else begin
                bus.insert_rrpv = LONG;
            end
        end
    end

endmodule
